// File: rtl/aes_display_pkg.sv
// Shared sizes, page index type and controller states for the AES display pager.
package aes_display_pkg;

   localparam int unsigned BLOCK_W    = 128;
   localparam int unsigned PAGE_W     = 16;
   localparam int unsigned NUM_PAGES  = 8;
   localparam int unsigned PAGE_IDX_W = $clog2(NUM_PAGES);

   typedef logic [PAGE_IDX_W-1:0] page_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REFRESH = 2'd1,
      SHOW    = 2'd2
   } state_e;

   // Page 0 is the most significant 16 bits; bit 0 of the block is its MSB.
   function automatic logic [0:PAGE_W-1] page_slice(input logic [0:BLOCK_W-1] blk,
                                                    input page_t idx);
      return blk[PAGE_W*int'(idx) +: PAGE_W];
   endfunction

endpackage

// File: rtl/aes_display_pager_dwell_timer.sv
// Dwell counter: clear_i zeroes it, en_i advances it; expire_o is high while enabled at DWELL_CYCLES-1.
// The count parks at its terminal value, so it never wraps.
module dwell_timer #(
   parameter int unsigned DWELL_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic clr,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned    CNT_W = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/aes_display_pager.sv
// Pages a 128-bit AES block onto a 16-bit display: accept -> strobe next cycle; ready low only in the strobe cycle.
// Auto-advance via dwell_timer exists only when AES_DISPLAY_PAGER_AUTO_EN is defined.
module aes_display_pager
   import aes_display_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 100_000_000
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               i_load_valid,
   output logic               o_load_ready,
   input  logic [0:BLOCK_W-1] i_load_data,
   input  logic               i_step_next,
   input  logic               i_step_prev,
   input  logic               i_hold,
   output logic [0:PAGE_W-1]  o_disp_data,
   output logic               o_disp_refresh,
   output logic [2:0]         o_page,
   output logic               o_busy
);

   state_e             state_q, state_d;
   logic [0:BLOCK_W-1] block_q, block_d;
   page_t              page_q, page_d;
   logic [0:PAGE_W-1]  disp_q, disp_d;
   logic               refresh_q;
   logic               accept;
   logic               step_one;
   logic               dwell_expire;

   assign o_load_ready   = (state_q != REFRESH);
   assign o_busy         = (state_q != IDLE);
   assign o_disp_data    = disp_q;
   assign o_disp_refresh = refresh_q;
   assign o_page         = page_q;

   assign accept   = i_load_valid && o_load_ready;
   // Opposing pulses in the same cycle cancel out.
   assign step_one = i_step_next ^ i_step_prev;

`ifdef AES_DISPLAY_PAGER_AUTO_EN
   dwell_timer #(
      .DWELL_CYCLES(DWELL_CYCLES)
   ) u_dwell_timer (
      .clk     (clk),
      .clr     (clr),
      .clear_i (state_q != SHOW),
      .en_i    ((state_q == SHOW) && !i_hold),
      .expire_o(dwell_expire)
   );
`else
   logic unused_cfg;
   assign unused_cfg   = i_hold ^ DWELL_CYCLES[0];
   assign dwell_expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      block_d = block_q;
      page_d  = page_q;
      if (accept) begin
         block_d = i_load_data;
         page_d  = '0;
         state_d = REFRESH;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            REFRESH: state_d = SHOW;
            SHOW: begin
               if (step_one) begin
                  page_d  = i_step_next ? page_q + page_t'(1) : page_q - page_t'(1);
                  state_d = REFRESH;
               end else if (dwell_expire) begin
                  page_d  = page_q + page_t'(1);
                  state_d = REFRESH;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Data is captured on the edge into REFRESH so it is valid alongside the strobe.
   always_comb begin
      disp_d = disp_q;
      if (state_d == REFRESH) begin
         disp_d = page_slice(block_d, page_d);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= IDLE;
         block_q   <= '0;
         page_q    <= '0;
         disp_q    <= '0;
         refresh_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         block_q   <= block_d;
         page_q    <= page_d;
         disp_q    <= disp_d;
         refresh_q <= (state_d == REFRESH);
      end
   end

endmodule

// File: tb/tb_aes_display_pager.sv
// Bench for aes_display_pager: directed vector table, hand-written corner sequences and random traffic vs a page model.
module tb_aes_display_pager;

   localparam int D = 4;
`ifdef AES_DISPLAY_PAGER_AUTO_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam logic [127:0] BLK  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] BLK2 = 128'hA1A2B1B2_C1C2D1D2_E1E2F1F2_01020304;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic         i_load_valid = 1'b0;
   logic [0:127] i_load_data = '0;
   logic         i_step_next = 1'b0;
   logic         i_step_prev = 1'b0;
   logic         i_hold = 1'b0;
   logic         o_load_ready;
   logic [0:15]  o_disp_data;
   logic         o_disp_refresh;
   logic [2:0]   o_page;
   logic         o_busy;

   always #5 clk = ~clk;

   aes_display_pager #(.DWELL_CYCLES(D)) dut (
      .clk           (clk),
      .clr           (clr),
      .i_load_valid  (i_load_valid),
      .o_load_ready  (o_load_ready),
      .i_load_data   (i_load_data),
      .i_step_next   (i_step_next),
      .i_step_prev   (i_step_prev),
      .i_hold        (i_hold),
      .o_disp_data   (o_disp_data),
      .o_disp_refresh(o_disp_refresh),
      .o_page        (o_page),
      .o_busy        (o_busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: which block is held, which page is up, whether this cycle strobes.
   bit          m_loaded;
   bit          m_strobe;
   int          m_page;
   int          m_dwell;
   logic [15:0] m_pg [8];
   logic [15:0] m_disp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_loaded = 0; m_strobe = 0; m_page = 0; m_dwell = 0; m_disp = '0;
      for (int k = 0; k < 8; k++) m_pg[k] = '0;
   endtask

   task automatic model_edge(input bit v, input logic [127:0] d, input bit n, input bit p, input bit h);
      if (v && !m_strobe) begin
         for (int k = 0; k < 8; k++) m_pg[k] = 16'(d >> (16 * (7 - k)));
         m_page = 0; m_disp = m_pg[0]; m_strobe = 1; m_loaded = 1;
      end else if (m_strobe) begin
         m_strobe = 0; m_dwell = 0;
      end else if (m_loaded) begin
         if (n != p) begin
            m_page = (m_page + (n ? 1 : 7)) % 8;
            m_disp = m_pg[m_page]; m_strobe = 1;
         end else if (AUTO && !h) begin
            if (m_dwell == D - 1) begin
               m_page = (m_page + 1) % 8;
               m_disp = m_pg[m_page]; m_strobe = 1;
            end else begin
               m_dwell++;
            end
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit v, input logic [127:0] d, input bit n, input bit p, input bit h);
      i_load_valid = v; i_load_data = d; i_step_next = n; i_step_prev = p; i_hold = h;
      @(posedge clk);
      model_edge(v, d, n, p, h);
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".refresh"}, 32'(o_disp_refresh), 32'(m_strobe));
      chk({tag, ".data"},    32'(o_disp_data),    32'(m_disp));
      chk({tag, ".page"},    32'(o_page),         32'(m_page));
      chk({tag, ".busy"},    32'(o_busy),         32'(m_loaded));
      chk({tag, ".ready"},   32'(o_load_ready),   32'(!m_strobe));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".refresh"}, 32'(o_disp_refresh), 32'd0);
      chk({tag, ".data"},    32'(o_disp_data),    32'd0);
      chk({tag, ".page"},    32'(o_page),         32'd0);
      chk({tag, ".busy"},    32'(o_busy),         32'd0);
      chk({tag, ".ready"},   32'(o_load_ready),   32'd1);
   endtask

   typedef struct {
      bit          v, n, p;
      bit          e_ref;
      logic [15:0] e_dat;
      int          e_pg;
      bit          e_busy;
      bit          e_rdy;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int cnt;
      int lat;

      tbl[0]  = '{1, 0, 0, 1, 16'h0011, 0, 1, 0};
      tbl[1]  = '{0, 0, 0, 0, 16'h0011, 0, 1, 1};
      tbl[2]  = '{0, 1, 0, 1, 16'h2233, 1, 1, 0};
      tbl[3]  = '{0, 0, 0, 0, 16'h2233, 1, 1, 1};
      tbl[4]  = '{0, 0, 1, 1, 16'h0011, 0, 1, 0};
      tbl[5]  = '{0, 0, 0, 0, 16'h0011, 0, 1, 1};
      tbl[6]  = '{0, 0, 1, 1, 16'hEEFF, 7, 1, 0};
      tbl[7]  = '{0, 0, 0, 0, 16'hEEFF, 7, 1, 1};
      tbl[8]  = '{0, 1, 1, 0, 16'hEEFF, 7, 1, 1};
      tbl[9]  = '{0, 1, 0, 1, 16'h0011, 0, 1, 0};
      tbl[10] = '{0, 0, 0, 0, 16'h0011, 0, 1, 1};

      #1 clr = 1'b1;
      #2 check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      model_reset();

      // Steps while idle are dropped.
      cycle(0, '0, 1, 0, 0);
      check_model("idle_step");

      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].v, BLK, tbl[i].n, tbl[i].p, 0);
         chk($sformatf("vec%0d.refresh", i), 32'(o_disp_refresh), 32'(tbl[i].e_ref));
         chk($sformatf("vec%0d.data", i),    32'(o_disp_data),    32'(tbl[i].e_dat));
         chk($sformatf("vec%0d.page", i),    32'(o_page),         32'(tbl[i].e_pg));
         chk($sformatf("vec%0d.busy", i),    32'(o_busy),         32'(tbl[i].e_busy));
         chk($sformatf("vec%0d.ready", i),   32'(o_load_ready),   32'(tbl[i].e_rdy));
      end

      // Free run: auto-advance walks the pages and wraps 7 -> 0.
      for (int i = 0; i < 45; i++) begin
         cycle(0, '0, 0, 0, 0);
         check_model($sformatf("dwell%0d", i));
      end

      // Fresh SHOW, let two dwell cycles pass, then freeze for 20 cycles.
      for (int i = 0; i < 6 && m_strobe; i++) cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 1, 0, 0);
      cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 0, 0, 0);
      check_model("pre_hold");
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, '0, 0, 0, 1);
         if (o_disp_refresh) cnt++;
         check_model($sformatf("hold%0d", i));
      end
      chk("hold_strobes", 32'(cnt), 32'd0);
      lat = 10;
      for (int i = 1; i <= 10; i++) begin
         cycle(0, '0, 0, 0, 0);
         check_model($sformatf("release%0d", i));
         if (o_disp_refresh) begin
            lat = i;
            break;
         end
      end
      chk("release_latency", 32'(lat), AUTO ? 32'd2 : 32'd10);

      // Load beats a simultaneous step.
      for (int i = 0; i < 6 && m_strobe; i++) cycle(0, '0, 0, 0, 0);
      cycle(1, BLK2, 1, 0, 0);
      check_model("load_vs_step");
      chk("load_vs_step.page0", 32'(o_page), 32'd0);
      chk("load_vs_step.data0", 32'(o_disp_data), 32'h0000A1A2);
      cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 0, 0, 0);

      // Asynchronous clear mid-SHOW.
      #2 clr = 1'b1;
      #1 check_reset_outputs("clr_async");
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      model_reset();
      check_model("after_clr");

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         bit v, n, p, h;
         logic [127:0] d;
         v = ($urandom_range(15) == 0);
         n = ($urandom_range(7) == 0);
         p = ($urandom_range(7) == 0);
         h = ($urandom_range(3) == 0);
         d = {$urandom, $urandom, $urandom, $urandom};
         cycle(v, d, n, p, h);
         check_model($sformatf("rnd%0d", i));
      end

      // Long idle after a load: only auto-advance may strobe.
      for (int i = 0; i < 6 && m_strobe; i++) cycle(0, '0, 0, 0, 0);
      cycle(1, BLK, 0, 0, 0);
      cycle(0, '0, 0, 0, 0);
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle(0, '0, 0, 0, 0);
         if (o_disp_refresh) cnt++;
         check_model($sformatf("idle%0d", i));
      end
      chk("idle_strobes", 32'(cnt), AUTO ? 32'd200 : 32'd0);
      for (int i = 0; i < 6 && m_strobe; i++) cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 1, 0, 0);
      check_model("final_step");
      chk("final_step.strobe", 32'(o_disp_refresh), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
